// File: rtl/hi_ssp_tx_pkg.sv
// Shared definitions for the FPGA->ARM SSP word transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hi_ssp_tx_pkg;

    // Transmitter FSM state encodings.
    typedef enum logic {
        HI_SSP_TX_IDLE  = 1'b0,
        HI_SSP_TX_SHIFT = 1'b1
    } hi_ssp_tx_state_e;

    localparam int UNDERRUN_W = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hi_ssp_tx_fifo.sv
// Word queue between HF mode producers and the SSP shift register.
// Latency: a pushed word is visible on dout on the next ck edge; dout is the head word.
// Backpressure: full blocks further pushes; flush empties the queue and overrides push/pop.
// Ports: ck_1356meg/nreset clock and async reset; push/din write side; pop/dout read side;
//        flush clears; full/empty are registered-state status.
module hi_ssp_tx_fifo
    import hi_ssp_tx_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ck_1356meg,
    input  logic              nreset,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] dout
);
    localparam int PTR_W = idx_w(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q alone decides which entries are valid.
    always_ff @(posedge ck_1356meg) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/hi_ssp_tx.sv
// FPGA->ARM SSP word transmitter: serialises queued words MSB-first on ssp_clk/ssp_frame/ssp_din.
// Latency: a word written while idle starts at the first ssp_clk rise after the write (<= 2*CLK_DIV+1 ck).
// Backpressure: wr_ready = FIFO not full (registered state only); enable=0 aborts and flushes.
// Ports: ck_1356meg/nreset clock and async reset; enable run/abort; wr_data/wr_valid/wr_ready
//        producer side; ssp_clk/ssp_frame/ssp_din serial side; busy activity flag;
//        underrun_cnt starvation counter, present only when HI_SSP_TX_UNDERRUN_EN is defined.
module hi_ssp_tx
    import hi_ssp_tx_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                  ck_1356meg,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  ssp_clk,
    output logic                  ssp_frame,
    output logic                  ssp_din,
`ifdef HI_SSP_TX_UNDERRUN_EN
    output logic [UNDERRUN_W-1:0] underrun_cnt,
`endif
    output logic                  busy
);
    localparam int DIV_W = idx_w(CLK_DIV);
    localparam int BIT_W = idx_w(WORD_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    hi_ssp_tx_state_e  state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              clk_q, clk_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              frame_q, frame_d;
    logic              rise, pop;
    logic              fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_dout;

    hi_ssp_tx_fifo #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .ck_1356meg (ck_1356meg),
        .nreset     (nreset),
        .push       (wr_valid),
        .din        (wr_data),
        .pop        (pop),
        .flush      (~enable),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .dout       (fifo_dout)
    );

    // Bit clock divider: free-running while enabled, parked low otherwise.
    always_comb begin
        div_d = div_q;
        clk_d = clk_q;
        if (!enable) begin
            div_d = '0;
            clk_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            clk_d = ~clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Edge where ssp_clk goes 0->1: the only point where serial state advances,
    // so data is settled half a period before the ARM samples on the fall.
    assign rise = enable & (div_q == DIV_LAST) & ~clk_q;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        frame_d  = frame_q;
        pop      = 1'b0;
        if (!enable) begin
            state_d  = HI_SSP_TX_IDLE;
            sh_d     = '0;
            bitcnt_d = '0;
            frame_d  = 1'b0;
        end else if (rise) begin
            frame_d = 1'b0;
            case (state_q)
                HI_SSP_TX_IDLE: begin
                    sh_d = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sh_d     = fifo_dout;
                        bitcnt_d = BIT_LAST;
                        frame_d  = 1'b1;
                        state_d  = HI_SSP_TX_SHIFT;
                    end
                end
                HI_SSP_TX_SHIFT: begin
                    if (bitcnt_q != '0) begin
                        sh_d     = sh_q << 1;
                        bitcnt_d = bitcnt_q - BIT_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word with no idle bit.
                        pop      = 1'b1;
                        sh_d     = fifo_dout;
                        bitcnt_d = BIT_LAST;
                        frame_d  = 1'b1;
                    end else begin
                        sh_d    = '0;
                        state_d = HI_SSP_TX_IDLE;
                    end
                end
                default: state_d = HI_SSP_TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state_q  <= HI_SSP_TX_IDLE;
            div_q    <= '0;
            clk_q    <= 1'b0;
            sh_q     <= '0;
            bitcnt_q <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            clk_q    <= clk_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
        end
    end

    assign ssp_clk   = clk_q;
    assign ssp_frame = frame_q;
    assign ssp_din   = sh_q[WORD_W-1];
    assign wr_ready  = ~fifo_full;
    assign busy      = (state_q == HI_SSP_TX_SHIFT) | ~fifo_empty;

`ifdef HI_SSP_TX_UNDERRUN_EN
    logic                  end_ev;
    logic [UNDERRUN_W-1:0] ur_q, ur_d;

    // Every natural end of a stream counts; a write landing in the same cycle
    // (too late to chain) is one such end, so it is covered here as well.
    // An abort via enable is not an FSM transition and leaves the count alone.
    assign end_ev = rise & (state_q == HI_SSP_TX_SHIFT) & (bitcnt_q == '0) & fifo_empty;

    always_comb begin
        ur_d = ur_q;
        if (end_ev && (ur_q != {UNDERRUN_W{1'b1}})) ur_d = ur_q + UNDERRUN_W'(1);
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) ur_q <= '0;
        else         ur_q <= ur_d;
    end

    assign underrun_cnt = ur_q;
`endif

endmodule

// File: tb/tb_hi_ssp_tx.sv
// Directed bench for hi_ssp_tx (WORD_W=16, FIFO_DEPTH=4, CLK_DIV=4).
// Inputs change and outputs are sampled on the falling ck edge.
// A serial monitor captures ssp_din/ssp_frame on every ssp_clk fall.
module tb_hi_ssp_tx;
    logic        ck_1356meg = 1'b0;
    logic        nreset     = 1'b1;
    logic        enable     = 1'b0;
    logic        wr_valid   = 1'b0;
    logic [15:0] wr_data    = 16'h0;
    logic        wr_ready, ssp_clk, ssp_frame, ssp_din, busy;
`ifdef HI_SSP_TX_UNDERRUN_EN
    logic [7:0]  underrun_cnt;
`endif

    hi_ssp_tx #(.WORD_W(16), .FIFO_DEPTH(4), .CLK_DIV(4)) dut (
        .ck_1356meg   (ck_1356meg),
        .nreset       (nreset),
        .enable       (enable),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame),
        .ssp_din      (ssp_din),
`ifdef HI_SSP_TX_UNDERRUN_EN
        .underrun_cnt (underrun_cnt),
`endif
        .busy         (busy)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   last_rise = -1;
    int   rise_period = 0;
    int   high_time = 0;
    bit   rose = 1'b0;
    logic prev_clk = 1'b0;
    logic q_bit[$];
    logic q_frm[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One ck cycle; also tracks ssp_clk edges and captures bits at each fall.
    task automatic tick();
        @(negedge ck_1356meg);
        cyc++;
        rose = 1'b0;
        if (!prev_clk && ssp_clk) begin
            if (last_rise >= 0) rise_period = cyc - last_rise;
            last_rise = cyc;
            rose = 1'b1;
        end
        if (prev_clk && !ssp_clk) begin
            high_time = cyc - last_rise;
            q_bit.push_back(ssp_din);
            q_frm.push_back(ssp_frame);
        end
        prev_clk = ssp_clk;
    endtask

    task automatic push_word(input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk(tag, busy, 1'b0);
    endtask

    task automatic clear_mon();
        q_bit.delete();
        q_frm.delete();
    endtask

    function automatic int first_frame();
        for (int i = 0; i < q_frm.size(); i++) if (q_frm[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int frame_count();
        int n = 0;
        for (int i = 0; i < q_frm.size(); i++) if (q_frm[i] === 1'b1) n++;
        return n;
    endfunction

    // 16 captured bits from idx (first captured bit lands in bit 15); missing bits are x.
    task automatic get_word(input int idx, output logic [15:0] w, output logic [15:0] f);
        for (int b = 0; b < 16; b++) begin
            int j;
            j = idx + b;
            if (idx >= 0 && j < q_bit.size()) begin
                w[15-b] = q_bit[j];
                f[15-b] = q_frm[j];
            end else begin
                w[15-b] = 1'bx;
                f[15-b] = 1'bx;
            end
        end
    endtask

    logic [15:0] w, f;
    logic [15:0] burst[4];
    logic [15:0] six[6];
    int s, bcnt;
    bit seen;

    initial begin
        burst = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
        six   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

        // 1. Reset held with a pending write and enable high.
        #1 nreset = 1'b0;
        enable   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        repeat (3) tick();
        chk("rst_ssp_clk", ssp_clk, 1'b0);
        chk("rst_frame", ssp_frame, 1'b0);
        chk("rst_din", ssp_din, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        wr_valid = 1'b0;
        nreset   = 1'b1;
        repeat (40) tick();
        chk("rst_no_write", busy, 1'b0);
        chk("clk_period", rise_period, 8);
        chk("clk_high", high_time, 4);

        // 2. Single word, MSB first, one frame pulse, busy for 16 bit periods.
        clear_mon();
        push_word(16'hA55A);
        seen = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            tick();
            if (ssp_frame) seen = 1'b1;
            if (seen && busy) bcnt++;
        end
        chk("t2_busy_time", bcnt, 128);
        chk("t2_busy_end", busy, 1'b0);
        repeat (40) tick();
        s = first_frame();
        get_word(s, w, f);
        chk("t2_word", w, 16'hA55A);
        chk("t2_frame", f, 16'h8000);
        chk("t2_frames", frame_count(), 1);
        get_word(s + 16, w, f);
        chk("t2_din_after", w[15:12], 4'h0);

        // 3. Burst of four: 64 contiguous bits, frames 16 bits apart.
        clear_mon();
        for (int k = 0; k < 4; k++) push_word(burst[k]);
        wait_idle("t3_idle", 800);
        repeat (40) tick();
        s = first_frame();
        for (int k = 0; k < 4; k++) begin
            get_word(s + 16 * k, w, f);
            chk($sformatf("t3_word%0d", k), w, burst[k]);
            chk($sformatf("t3_frame%0d", k), f, 16'h8000);
        end
        chk("t3_frames", frame_count(), 4);
        get_word(s + 64, w, f);
        chk("t3_din_after", w[15:12], 4'h0);

        // 4. Six pushes at 1/ck, first push one ck before a rise event:
        //    word 0 is popped while word 1 arrives, words 1..4 fill the FIFO, word 5 is dropped.
        clear_mon();
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) tick();
        chk("t4_align", rose, 1'b1);
        repeat (6) tick();
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1;
            wr_data  = six[k];
            if (k == 4) chk("t4_rdy_before_full", wr_ready, 1'b1);
            if (k == 5) chk("t4_rdy_full", wr_ready, 1'b0);
            tick();
        end
        wr_valid = 1'b0;
        wait_idle("t4_idle", 1000);
        repeat (40) tick();
        s = first_frame();
        for (int k = 0; k < 5; k++) begin
            get_word(s + 16 * k, w, f);
            chk($sformatf("t4_word%0d", k), w, six[k]);
        end
        chk("t4_frames", frame_count(), 5);
        chk("t4_rdy_end", wr_ready, 1'b1);

        // 5. Abort during bit 7 of 16'h1234 with three words queued.
        clear_mon();
        push_word(16'h1234);
        for (int i = 0; i < 50 && !ssp_frame; i++) tick();
        chk("t5_frame_seen", ssp_frame, 1'b1);
        push_word(16'hAAAA);
        push_word(16'hBBBB);
        push_word(16'hCCCC);
        repeat (63) tick();
        chk("t5_pre_clk", ssp_clk, 1'b1);
        chk("t5_pre_busy", busy, 1'b1);
        enable = 1'b0;
        tick();
        chk("t5_clk", ssp_clk, 1'b0);
        chk("t5_din", ssp_din, 1'b0);
        chk("t5_frame", ssp_frame, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_wr_ready", wr_ready, 1'b1);
        s = first_frame();
        get_word(s, w, f);
        chk("t5_sent_hi", w[15:8], 8'h12);
        repeat (5) tick();
        enable = 1'b1;
        clear_mon();
        repeat (300) tick();
        chk("t5_nothing_sent", frame_count(), 0);
        chk("t5_idle", busy, 1'b0);

`ifdef HI_SSP_TX_UNDERRUN_EN
        // 6. Three streams have ended so far (tests 2, 3, 4); the abort does not count.
        chk("t6_base", underrun_cnt, 8'd3);
        push_word(16'h0F0F);
        wait_idle("t6_idle_a", 400);
        repeat (40) tick();
        push_word(16'hF0F0);
        wait_idle("t6_idle_b", 400);
        chk("t6_separated", underrun_cnt, 8'd5);
        push_word(16'h1357);
        push_word(16'h2468);
        wait_idle("t6_idle_c", 600);
        chk("t6_back_to_back", underrun_cnt, 8'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
